// File: rtl/glitch_seq_pkg.sv
// Shared state encoding and configuration helpers for the glitch sequencer.
package glitch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_DELAY     = 3'd3,
    ST_PULSE     = 3'd4,
    ST_GAP       = 3'd5,
    ST_DONE      = 3'd6
  } seq_state_t;

  // Zero-valued width/gap/count settings behave as 1.
  function automatic logic [31:0] clamp_to_one(input logic [31:0] value);
    return (value == 32'd0) ? 32'd1 : value;
  endfunction

endpackage

// File: rtl/glitch_sequencer_down_counter.sv
// Loadable down counter that holds at zero, with a zero flag for the FSM.
module down_counter
  import glitch_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/glitch_sequencer.sv
// Sequences one glitch attempt: arm the edge detector, wait for its trigger,
// delay, then emit a burst of pulses with programmable width, gap and count.
module glitch_sequencer
  import glitch_seq_pkg::*;
#(
  parameter int DELAY_W        = 16,
  parameter int WIDTH_W        = 8,
  parameter int COUNT_W        = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [WIDTH_W-1:0] cfg_width,
  input  logic [WIDTH_W-1:0] cfg_gap,
  input  logic [COUNT_W-1:0] cfg_count,
  input  logic               trigger,
  output logic               arm,
  output logic               glitch,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               aborted
);

  // Delay and trigger timeout share one counter, so it must hold either range.
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DC_W = (TO_W > DELAY_W) ? TO_W : DELAY_W;
  localparam logic [DC_W-1:0] TO_LOAD = DC_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  seq_state_t         state_reg, state_next;
  logic [DELAY_W-1:0] delay_reg;
  logic [WIDTH_W-1:0] width_reg, gap_reg;
  logic [COUNT_W-1:0] remain_reg, remain_next;

  logic               start_take;
  logic               dc_load, dc_dec, dc_zero;
  logic [DC_W-1:0]    dc_value;
  logic               wc_load, wc_dec, wc_zero;
  logic [WIDTH_W-1:0] wc_value;
  logic               timeout_next, aborted_next;

  down_counter #(.W(DC_W)) u_delay_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (dc_load),
    .dec   (dc_dec),
    .value (dc_value),
    .zero  (dc_zero)
  );

  down_counter #(.W(WIDTH_W)) u_width_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (wc_load),
    .dec   (wc_dec),
    .value (wc_value),
    .zero  (wc_zero)
  );

  // Counters are loaded with (length - 1) so each state lasts exactly its length.
  always_comb begin
    state_next   = state_reg;
    remain_next  = remain_reg;
    start_take   = 1'b0;
    dc_load      = 1'b0;
    dc_dec       = 1'b0;
    dc_value     = '0;
    wc_load      = 1'b0;
    wc_dec       = 1'b0;
    wc_value     = '0;
    timeout_next = 1'b0;
    aborted_next = 1'b0;

    if (abort && (state_reg != ST_IDLE)) begin
      state_next   = ST_IDLE;
      aborted_next = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && !abort) begin
            start_take  = 1'b1;
            remain_next = COUNT_W'(clamp_to_one(32'(cfg_count)));
            state_next  = ST_ARM;
          end
        end
        ST_ARM: begin
          dc_load    = 1'b1;
          dc_value   = TO_LOAD;
          state_next = ST_WAIT_TRIG;
        end
        ST_WAIT_TRIG: begin
          if (trigger) begin
            if (delay_reg == '0) begin
              wc_load    = 1'b1;
              wc_value   = width_reg - WIDTH_W'(1);
              state_next = ST_PULSE;
            end else begin
              dc_load    = 1'b1;
              dc_value   = DC_W'(delay_reg) - DC_W'(1);
              state_next = ST_DELAY;
            end
          end else if (TO_EN && dc_zero) begin
            timeout_next = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            dc_dec = 1'b1;
          end
        end
        ST_DELAY: begin
          if (dc_zero) begin
            wc_load    = 1'b1;
            wc_value   = width_reg - WIDTH_W'(1);
            state_next = ST_PULSE;
          end else begin
            dc_dec = 1'b1;
          end
        end
        ST_PULSE: begin
          if (wc_zero) begin
            remain_next = remain_reg - COUNT_W'(1);
            if (remain_reg != COUNT_W'(1)) begin
              wc_load    = 1'b1;
              wc_value   = gap_reg - WIDTH_W'(1);
              state_next = ST_GAP;
            end else begin
              state_next = ST_DONE;
            end
          end else begin
            wc_dec = 1'b1;
          end
        end
        ST_GAP: begin
          if (wc_zero) begin
            wc_load    = 1'b1;
            wc_value   = width_reg - WIDTH_W'(1);
            state_next = ST_PULSE;
          end else begin
            wc_dec = 1'b1;
          end
        end
        ST_DONE: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they align with state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      delay_reg  <= '0;
      width_reg  <= '0;
      gap_reg    <= '0;
      remain_reg <= '0;
      arm        <= 1'b0;
      glitch     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      remain_reg <= remain_next;
      if (start_take) begin
        delay_reg <= cfg_delay;
        width_reg <= WIDTH_W'(clamp_to_one(32'(cfg_width)));
        gap_reg   <= WIDTH_W'(clamp_to_one(32'(cfg_gap)));
      end
      arm     <= (state_next == ST_ARM);
      glitch  <= (state_next == ST_PULSE);
      busy    <= (state_next != ST_IDLE);
      done    <= (state_next == ST_DONE);
      timeout <= timeout_next;
      aborted <= aborted_next;
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Randomized bench for glitch_sequencer against a cycle-timeline reference model.
module tb_glitch_sequencer;

  localparam int DELAY_W        = 8;
  localparam int WIDTH_W        = 8;
  localparam int COUNT_W        = 4;
  localparam int TIMEOUT_CYCLES = 10;
  localparam int MAXC           = 512;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               trigger = 1'b0;
  logic [DELAY_W-1:0] cfg_delay = '0;
  logic [WIDTH_W-1:0] cfg_width = '0;
  logic [WIDTH_W-1:0] cfg_gap = '0;
  logic [COUNT_W-1:0] cfg_count = '0;
  logic               arm, glitch, busy, done, timeout, aborted;

  int tests_run = 0;
  int failures  = 0;
  int txn_id    = 0;

  // Expected outputs per cycle, packed {arm, glitch, busy, done, timeout, aborted}.
  logic [5:0] exp_out [MAXC];
  bit         drv_start [MAXC];
  bit         drv_trig  [MAXC];
  bit         drv_abort [MAXC];

  always #5 clk = ~clk;

  glitch_sequencer #(
    .DELAY_W        (DELAY_W),
    .WIDTH_W        (WIDTH_W),
    .COUNT_W        (COUNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_delay (cfg_delay),
    .cfg_width (cfg_width),
    .cfg_gap   (cfg_gap),
    .cfg_count (cfg_count),
    .trigger   (trigger),
    .arm       (arm),
    .glitch    (glitch),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .aborted   (aborted)
  );

  function automatic logic [5:0] outs();
    return {arm, glitch, busy, done, timeout, aborted};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Cycle 0 carries start; trigger driven in cycle t is seen in WAIT_TRIG only for
  // t in [2, TIMEOUT_CYCLES+1], giving glitches from cycle t+1+delay.
  task automatic run_txn(input int d, input int w, input int g, input int n,
                         input int trig_cyc, input int abort_cyc, input bit extra);
    int  wc, gc, nc, first, end_c, run_len, lo, c;
    bit  hit;
    wc = (w == 0) ? 1 : w;
    gc = (g == 0) ? 1 : g;
    nc = (n == 0) ? 1 : n;
    for (int i = 0; i < MAXC; i++) begin
      exp_out[i]   = '0;
      drv_start[i] = 1'b0;
      drv_trig[i]  = 1'b0;
      drv_abort[i] = 1'b0;
    end
    drv_start[0] = 1'b1;
    exp_out[1][5] = 1'b1;
    if (trig_cyc >= 0) drv_trig[trig_cyc] = 1'b1;
    hit = (trig_cyc >= 2) && (trig_cyc <= TIMEOUT_CYCLES + 1);
    if (hit) begin
      first = trig_cyc + 1 + d;
      for (int p = 0; p < nc; p++)
        for (int j = 0; j < wc; j++)
          exp_out[first + p * (wc + gc) + j][4] = 1'b1;
      end_c = first + nc * wc + (nc - 1) * gc;
      exp_out[end_c][2] = 1'b1;
      for (int i = 1; i <= end_c; i++) exp_out[i][3] = 1'b1;
    end else begin
      end_c = TIMEOUT_CYCLES + 2;
      exp_out[end_c][1] = 1'b1;
      for (int i = 1; i < end_c; i++) exp_out[i][3] = 1'b1;
    end
    if (abort_cyc == 0) begin
      drv_abort[0] = 1'b1;
      for (int i = 0; i < MAXC; i++) exp_out[i] = '0;
    end else if (abort_cyc > 0) begin
      drv_abort[abort_cyc] = 1'b1;
      if (exp_out[abort_cyc][3]) begin
        for (int i = abort_cyc + 1; i < MAXC; i++) exp_out[i] = '0;
        exp_out[abort_cyc + 1][0] = 1'b1;
      end
    end
    run_len = ((abort_cyc + 1 > end_c) ? abort_cyc + 1 : end_c) + 3;
    if (extra) begin
      for (int k = 0; k < 3; k++) begin
        c = $urandom_range(1, run_len - 1);
        if (exp_out[c][3]) drv_start[c] = 1'b1;
      end
      drv_trig[1] = 1'($urandom_range(0, 1));
      lo = hit ? trig_cyc + 1 : TIMEOUT_CYCLES + 2;
      for (int k = 0; k < 3; k++)
        if (lo < run_len) drv_trig[$urandom_range(lo, run_len - 1)] = 1'b1;
    end

    for (int cy = 0; cy < run_len; cy++) begin
      @(negedge clk);
      check_eq($sformatf("txn%0d_cyc%0d", txn_id, cy), 32'(outs()), 32'(exp_out[cy]));
      start   = drv_start[cy];
      trigger = drv_trig[cy];
      abort   = drv_abort[cy];
      if (cy == 0) begin
        cfg_delay = DELAY_W'(d);
        cfg_width = WIDTH_W'(w);
        cfg_gap   = WIDTH_W'(g);
        cfg_count = COUNT_W'(n);
      end else begin
        cfg_delay = DELAY_W'($urandom);
        cfg_width = WIDTH_W'($urandom);
        cfg_gap   = WIDTH_W'($urandom);
        cfg_count = COUNT_W'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0; trigger = 1'b0; abort = 1'b0;
    $display("[TB] txn %0d d=%0d w=%0d g=%0d n=%0d trig=%0d abort=%0d cycles=%0d checks=%0d",
             txn_id, d, w, g, n, trig_cyc, abort_cyc, run_len, tests_run);
    txn_id++;
  endtask

  // Asynchronous reset k cycles after start; delay 20 puts cycle 10 in DELAY, 25 in PULSE.
  task automatic reset_test(input int k, input logic exp_glitch);
    for (int c = 0; c <= k; c++) begin
      @(negedge clk);
      start   = (c == 0);
      trigger = (c == 2);
      if (c == 0) begin
        cfg_delay = DELAY_W'(20);
        cfg_width = WIDTH_W'(8);
        cfg_gap   = WIDTH_W'(1);
        cfg_count = COUNT_W'(1);
      end
    end
    check_eq($sformatf("pre_rst%0d_busy", k), 32'(busy), 32'd1);
    check_eq($sformatf("pre_rst%0d_glitch", k), 32'(glitch), 32'(exp_glitch));
    #2 rst = 1'b1;
    #1 check_eq($sformatf("async_rst%0d_outs", k), 32'(outs()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq($sformatf("post_rst%0d_outs", k), 32'(outs()), 32'd0);
    $display("[TB] reset test at cycle %0d checks=%0d", k, tests_run);
  endtask

  initial begin
    int d, w, g, n, t, a;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", 32'(outs()), 32'd0);
    rst = 1'b0;

    run_txn(3,   1, 0, 1,  4, -1, 1'b0);  // basic sequence (width 2 below)
    run_txn(3,   2, 0, 1,  4, -1, 1'b0);
    run_txn(0,   1, 2, 3,  5, -1, 1'b0);  // burst
    run_txn(1,   0, 0, 0,  3, -1, 1'b0);  // zero clamping
    run_txn(2,   1, 1, 1, -1, -1, 1'b0);  // timeout
    run_txn(2,   8, 1, 2,  3,  8, 1'b0);  // abort in third glitch cycle
    run_txn(1,   3, 2, 2,  2, -1, 1'b1);  // restart after abort, with ignored inputs
    run_txn(2,   2, 2, 2,  3,  0, 1'b0);  // start and abort together
    run_txn(1,   1, 1, 1, 11, -1, 1'b0);  // trigger in the last wait cycle
    run_txn(1,   1, 1, 1, 12, -1, 1'b0);  // trigger one cycle too late
    run_txn(255, 1, 1, 1,  6, -1, 1'b0);  // maximum delay
    run_txn(0,   2, 3, 15, 2, -1, 1'b1);  // maximum count

    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 10);
      w = $urandom_range(0, 4);
      g = $urandom_range(0, 4);
      n = $urandom_range(0, 5);
      t = $urandom_range(2, 13);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
      run_txn(d, w, g, n, t, a, 1'b1);
    end

    reset_test(10, 1'b0);
    reset_test(25, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
Controller that sequences one glitch attempt around the edge detector.
- On `start`, latches a configuration and issues a one-cycle `arm` pulse to detect_edge.
- Waits for the detector's `trigger`, counts a programmable delay, then emits a burst of glitch pulses with programmable width, count and gap.
- Sits between the host command/config registers and the glitch output driver. Provides `busy`, `done` and error status.

Parameters:
DELAY_W, 16, width of cfg_delay and the delay counter
WIDTH_W, 8, width of cfg_width and cfg_gap, and of the pulse/gap counter
COUNT_W, 4, width of cfg_count, the pulse-count register
TIMEOUT_CYCLES, 0, cycles to wait for trigger before giving up; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin sequence; sampled only in IDLE
abort  in  1  cancel sequence; any state
cfg_delay  in  DELAY_W  cycles from trigger to first glitch
cfg_width  in  WIDTH_W  glitch high cycles; 0 is treated as 1
cfg_gap  in  WIDTH_W  low cycles between pulses; 0 is treated as 1
cfg_count  in  COUNT_W  number of pulses; 0 is treated as 1
trigger  in  1  from detect_edge
arm  out  1  one-cycle arm pulse to detect_edge
glitch  out  1  glitch drive
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal completion
timeout  out  1  one-cycle pulse when the trigger wait expires
aborted  out  1  one-cycle pulse when an abort is taken outside IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port `rst`.
- Reset: state = IDLE, all counters = 0, all outputs = 0.
- All outputs are registered and decoded from the next state, so they change on the clock edge that enters a state.
- States: IDLE, ARM, WAIT_TRIG, DELAY, PULSE, GAP, DONE.
- IDLE:
  - start=1 → latch cfg_* into internal registers (zero values clamped to 1 where noted above).
  - Go to ARM.
  - cfg_* changes after this point are ignored until the next start.
- ARM: lasts exactly 1 cycle; arm=1. → WAIT_TRIG, with the timeout counter cleared.
- WAIT_TRIG:
  - trigger=1 → DELAY, or straight to PULSE if delay=0.
  - Otherwise, if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES → IDLE with timeout=1 for 1 cycle.
  - A trigger in the ARM cycle itself is ignored.
- Latency: trigger sampled high at edge k → glitch first high after edge k+1+cfg_delay.
- DELAY: counter runs from cfg_delay down; on reaching 0 → PULSE.
- PULSE:
  - glitch=1 for exactly width cycles.
  - Then decrement the remaining-pulse count.
  - If the count is nonzero → GAP; otherwise → DONE.
- GAP: glitch=0 for exactly gap cycles, then → PULSE.
- DONE: done=1 for 1 cycle, then → IDLE. busy stays high in the DONE cycle.
- abort:
  - Has priority over every other transition.
  - From any non-IDLE state: next edge → IDLE, glitch=0, aborted=1 for 1 cycle, no done.
  - In IDLE, abort is ignored; if start and abort are both high, abort wins and no sequence starts.
- Counters:
  - Delay counter saturates at 0; the others are sized so they cannot wrap.
  - cfg_delay at its maximum value (all ones) is legal and gives the full 2^DELAY_W−1 cycle delay.
- start while busy is ignored; it is not queued.
- Asynchronous reset mid-pulse drops glitch immediately. No status pulse is generated.

Decomposition:
- Package glitch_seq_pkg holds the state enum type (`seq_state_t`) and the clamp-to-1 helper function.
- One sub-module, `down_counter`: loadable, parametric width, with a zero flag.
  - Instantiated once for delay/timeout, sharing one counter because the two states are mutually exclusive.
  - Instantiated once for width/gap.
- The pulse count lives in the FSM.

Test Plan:
1. Basic sequence
   - Stimulus: delay=3, width=2, count=1, start; trigger pulse at cycle T.
   - Required: arm high 1 cycle after start; glitch high at T+4 and T+5; done at T+6; busy falls at T+7.
2. Burst
   - Stimulus: delay=0, width=1, gap=2, count=3.
   - Required: glitch pattern starting at T+1 is 1,0,0,1,0,0,1; then done.
3. Zero clamping
   - Stimulus: width=0, gap=0, count=0.
   - Required: exactly one 1-cycle glitch.
4. Timeout
   - Stimulus: TIMEOUT_CYCLES=10, no trigger.
   - Required: timeout pulses 10 cycles after entering WAIT_TRIG; glitch never rises; busy then falls.
5. Abort mid-PULSE (width=8)
   - Stimulus: abort asserted in the 3rd glitch cycle.
   - Required: glitch low on the next edge; aborted=1; done never pulses; a new start then works normally.
6. Ignored inputs
   - Stimulus: start while busy, and trigger pulses during DELAY or GAP.
   - Required: no effect on timing or pulse count.
   - Stimulus: reset asserted mid-DELAY.
   - Required: all outputs 0 without waiting for a clock edge.
